// File: rtl/sign_mag_addsub_pipe.sv
// Two-stage sign-magnitude add/subtract with valid/ready handshake; result 2 cycles after accept.
// in_ready drops only when both stages hold a beat and the sink stalls; no skid buffer.
module sign_mag_addsub_pipe #(
    parameter int N   = 4,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         ovf,
    output logic         ovf_sticky,
    input  logic         clr_sticky
);
    localparam int M = N - 1;

    logic         s1_valid;
    logic [M-1:0] mag_big;
    logic [M-1:0] mag_small;
    logic         sign_big;
    logic         eff_sub;

    logic         adv2;
    logic [M-1:0] mag_a;
    logic [M-1:0] mag_b;
    logic         sign_a;
    logic         sign_b;
    logic         a_ge_b;

    logic [N-1:0] sum;
    logic         carry;
    logic [M-1:0] mag_res;
    logic         sign_res;

    assign adv2     = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | adv2;

    // Zero magnitude is folded to +0 up front so -0 never steers the sign.
    assign mag_a  = a[M-1:0];
    assign mag_b  = b[M-1:0];
    assign sign_a = a[N-1] & (|mag_a);
    assign sign_b = (b[N-1] ^ op) & (|mag_b);
    assign a_ge_b = (mag_a >= mag_b);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            mag_big   <= '0;
            mag_small <= '0;
            sign_big  <= 1'b0;
            eff_sub   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                mag_big   <= a_ge_b ? mag_a : mag_b;
                mag_small <= a_ge_b ? mag_b : mag_a;
                sign_big  <= a_ge_b ? sign_a : sign_b;
                eff_sub   <= sign_a ^ sign_b;
            end
        end
    end

    // Operands are ordered, so the subtract path never borrows.
    assign sum      = eff_sub ? ({1'b0, mag_big} - {1'b0, mag_small})
                              : ({1'b0, mag_big} + {1'b0, mag_small});
    assign carry    = sum[M];
    assign mag_res  = (SAT && carry) ? {M{1'b1}} : sum[M-1:0];
    assign sign_res = sign_big & (|mag_res);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            s         <= '0;
            ovf       <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                s   <= {sign_res, mag_res};
                ovf <= carry;
            end
        end
    end

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && ovf) begin
            ovf_sticky <= 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sign_mag_addsub_pipe.sv
// Bench for sign_mag_addsub_pipe: wrap and saturate instances side by side,
// directed cases then a randomized stream scored against an integer-arithmetic model.
module tb_sign_mag_addsub_pipe;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_ready;
    logic         clr_sticky;

    logic         in_ready0, out_valid0, ovf0, sticky0;
    logic [N-1:0] s0;
    logic         in_ready1, out_valid1, ovf1, sticky1;
    logic [N-1:0] s1;

    sign_mag_addsub_pipe #(.N(N), .SAT(1'b0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .op(op), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .s(s0), .ovf(ovf0), .ovf_sticky(sticky0), .clr_sticky(clr_sticky)
    );

    sign_mag_addsub_pipe #(.N(N), .SAT(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .op(op), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .s(s1), .ovf(ovf1), .ovf_sticky(sticky1), .clr_sticky(clr_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] sw;
        logic [N-1:0] ss;
        logic         ov;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_acc = 0;
    logic         exp_sticky = 1'b0;
    logic         hold = 1'b0;
    logic [N-1:0] hold_s0, hold_s1;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Signed integer view of the operation, then wrap or clamp the magnitude.
    function automatic exp_t model(input logic [N-1:0] ai, input logic [N-1:0] bi, input logic opi);
        exp_t e;
        int   lim, va, vb, r, mag, w, st;
        lim = (1 << (N - 1)) - 1;
        va  = ai[N-1] ? -int'(ai[N-2:0]) : int'(ai[N-2:0]);
        vb  = bi[N-1] ? -int'(bi[N-2:0]) : int'(bi[N-2:0]);
        r   = opi ? va - vb : va + vb;
        mag = (r < 0) ? -r : r;
        w   = mag % (lim + 1);
        st  = (mag > lim) ? lim : mag;
        e.ov = (mag > lim);
        e.sw = {(r < 0) && (w != 0), w[N-2:0]};
        e.ss = {(r < 0) && (st != 0), st[N-2:0]};
        return e;
    endfunction

    task automatic sb_cycle(input logic iv, input logic orr, input logic clr);
        exp_t e;
        logic exp_ready;
        in_valid   = iv;
        out_ready  = orr;
        clr_sticky = clr;
        a  = N'($urandom);
        b  = N'($urandom);
        op = 1'($urandom);
        #1;
        exp_ready = !(q.size() == 2 && !orr);
        check("in_ready", {7'd0, in_ready0}, {7'd0, exp_ready});
        check("in_ready_sat", {7'd0, in_ready1}, {7'd0, exp_ready});
        check("sticky", {7'd0, sticky0}, {7'd0, exp_sticky});
        check("sticky_sat", {7'd0, sticky1}, {7'd0, exp_sticky});
        if (hold) begin
            check("stall_valid", {7'd0, out_valid0}, 8'd1);
            check("stall_s", {4'd0, s0}, {4'd0, hold_s0});
            check("stall_s_sat", {4'd0, s1}, {4'd0, hold_s1});
        end
        hold    = out_valid0 && !orr;
        hold_s0 = s0;
        hold_s1 = s1;
        if (out_valid0 && orr) begin
            if (q.size() == 0) begin
                check("spurious_out", {7'd0, out_valid0}, 8'd0);
            end else begin
                e = q.pop_front();
                check("s_wrap", {4'd0, s0}, {4'd0, e.sw});
                check("s_sat", {4'd0, s1}, {4'd0, e.ss});
                check("ovf", {7'd0, ovf0}, {7'd0, e.ov});
                check("ovf_sat", {7'd0, ovf1}, {7'd0, e.ov});
                if (e.ov) exp_sticky = 1'b1;
                else if (clr) exp_sticky = 1'b0;
            end
        end else if (clr) begin
            exp_sticky = 1'b0;
        end
        if (iv && exp_ready) begin
            q.push_back(model(a, b, op));
            n_acc++;
        end
        step();
    endtask

    // Single beat through an empty pipe with exact 2-cycle latency.
    task automatic one_op(input string tag, input logic [N-1:0] ai, input logic [N-1:0] bi,
                          input logic opi, input logic [N-1:0] es, input logic [N-1:0] ess,
                          input logic eov, input logic clr_at_consume);
        in_valid   = 1'b1;
        a          = ai;
        b          = bi;
        op         = opi;
        out_ready  = 1'b1;
        clr_sticky = 1'b0;
        #1;
        check({tag, "_in_ready"}, {7'd0, in_ready0}, 8'd1);
        step();
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, {7'd0, out_valid0}, 8'd0);
        step();
        check({tag, "_lat2_valid"}, {7'd0, out_valid0}, 8'd1);
        check({tag, "_lat2_valid_sat"}, {7'd0, out_valid1}, 8'd1);
        check({tag, "_s"}, {4'd0, s0}, {4'd0, es});
        check({tag, "_s_sat"}, {4'd0, s1}, {4'd0, ess});
        check({tag, "_ovf"}, {7'd0, ovf0}, {7'd0, eov});
        check({tag, "_ovf_sat"}, {7'd0, ovf1}, {7'd0, eov});
        clr_sticky = clr_at_consume;
        step();
        clr_sticky = 1'b0;
        if (eov) exp_sticky = 1'b1;
        else if (clr_at_consume) exp_sticky = 1'b0;
        check({tag, "_sticky"}, {7'd0, sticky0}, {7'd0, exp_sticky});
        check({tag, "_sticky_sat"}, {7'd0, sticky1}, {7'd0, exp_sticky});
        check({tag, "_drained"}, {7'd0, out_valid0}, 8'd0);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && q.size() > 0; i++) sb_cycle(1'b0, 1'b1, 1'b0);
        check(tag, 8'(q.size()), 8'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        op = 1'b0; a = '0; b = '0;
        step();
        step();
        check("rst_out_valid", {7'd0, out_valid0}, 8'd0);
        check("rst_s", {4'd0, s0}, 8'd0);
        check("rst_ovf", {7'd0, ovf0}, 8'd0);
        check("rst_sticky", {7'd0, sticky0}, 8'd0);
        check("rst_in_ready", {7'd0, in_ready0}, 8'd1);
        reset = 1'b0;

        one_op("add_mixed", 4'b0011, 4'b1101, 1'b0, 4'b1010, 4'b1010, 1'b0, 1'b0);
        one_op("sub_equal", 4'b0101, 4'b0101, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        one_op("add_negzero", 4'b1000, 4'b1000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        one_op("sub_negzero", 4'b0011, 4'b1000, 1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0);
        one_op("add_ovf", 4'b0111, 4'b0001, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b0);
        one_op("neg_ovf", 4'b1110, 4'b0011, 1'b1, 4'b1001, 4'b1111, 1'b1, 1'b0);

        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        exp_sticky = 1'b0;
        check("sticky_cleared", {7'd0, sticky0}, 8'd0);

        one_op("ovf_with_clr", 4'b0111, 4'b0001, 1'b0, 4'b0000, 4'b0111, 1'b1, 1'b1);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        exp_sticky = 1'b0;

        // Backpressure: sink stalls for three cycles while the source streams.
        hold  = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 3; i++) sb_cycle(1'b1, 1'b0, 1'b0);
        check("bp_accepts", 8'(n_acc), 8'd2);
        for (int i = 0; i < 20 && n_acc < 4; i++) sb_cycle(1'b1, 1'b1, 1'b0);
        check("bp_all_accepted", 8'(n_acc), 8'd4);
        drain("bp_drain");

        // Reset with two beats in flight.
        one_op("pre_rst_ovf", 4'b0111, 4'b0111, 1'b0, 4'b0110, 4'b0111, 1'b1, 1'b0);
        sb_cycle(1'b1, 1'b0, 1'b0);
        sb_cycle(1'b1, 1'b0, 1'b0);
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        q.delete();
        exp_sticky = 1'b0;
        hold = 1'b0;
        check("midrst_out_valid", {7'd0, out_valid0}, 8'd0);
        check("midrst_sticky", {7'd0, sticky0}, 8'd0);
        check("midrst_in_ready", {7'd0, in_ready0}, 8'd1);
        one_op("post_rst", 4'b0010, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++)
            sb_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 19) == 0);
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
